// File: rtl/uart_rx_os.sv
// UART receiver with internal oversampling baud generator, 3-sample majority
// voting, parity/framing/break/overrun detection and a ready/valid output stage.
module uart_rx_os #(
    parameter int CLK_FREQ    = 16_000_000,
    parameter int BAUD_RATE   = 9_600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun,
    output logic                  busy
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam bit HAS_PAR = (PARITY_MODE != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  perr;
        logic                  ferr;
        logic                  brk;
    } frame_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rxs, rxs_d, fall;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      smp_cnt, smp_nxt;
    logic                 tick, bnd, dec, bit_val;
    logic                 s0, s1;
    logic [BIT_W-1:0]     bit_idx;
    logic [0:0]           stop_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                 par_bit, exp_par;
    logic                 perr_p, ferr_p, brk_p, brk_hit;
    logic                 done;
    frame_t               frame_nxt;

    // Input synchroniser; idle-high so reset must not fake a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_d  <= rxs;
        end
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_d & ~rxs;

    // Sample count is the tick index within the bit after the advancing tick;
    // the tick that wraps it to 0 is the bit boundary.
    assign tick    = (state_q != S_IDLE) && (div_cnt == DIV_W'(DIV - 1));
    assign smp_nxt = (smp_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : smp_cnt + OS_W'(1);
    assign bnd     = tick && (smp_cnt == OS_W'(OVERSAMPLE - 1));
    assign dec     = tick && (smp_nxt == OS_W'(OVERSAMPLE / 2 + 1));
    assign bit_val = (s0 & s1) | (s0 & rxs) | (s1 & rxs);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            smp_cnt <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
        end else if (state_q == S_IDLE) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                smp_cnt <= smp_nxt;
                if (smp_nxt == OS_W'(OVERSAMPLE / 2 - 1)) s0 <= rxs;
                if (smp_nxt == OS_W'(OVERSAMPLE / 2))     s1 <= rxs;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fall) state_d = S_START;
            S_START: begin
                if (dec && bit_val) state_d = S_IDLE;
                else if (bnd)       state_d = S_DATA;
            end
            S_DATA:   if (bnd && bit_idx == BIT_W'(DATA_WIDTH - 1))
                          state_d = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (bnd) state_d = S_STOP;
            S_STOP:   if (dec && stop_idx == 1'(STOP_BITS - 1)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_STOP) && dec && (stop_idx == 1'(STOP_BITS - 1));
    end

    assign exp_par = (PARITY_MODE == 2) ? ~(^shreg) : ^shreg;
    assign brk_hit = (stop_idx == 1'b0) && !bit_val && (shreg == '0) && !(HAS_PAR && par_bit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx  <= '0;
            stop_idx <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            perr_p   <= 1'b0;
            ferr_p   <= 1'b0;
            brk_p    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bit_idx  <= '0;
                    stop_idx <= '0;
                    shreg    <= '0;
                    par_bit  <= 1'b0;
                    perr_p   <= 1'b0;
                    ferr_p   <= 1'b0;
                    brk_p    <= 1'b0;
                end
                S_DATA: begin
                    if (dec) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
                    if (bnd) bit_idx <= bit_idx + BIT_W'(1);
                end
                S_PARITY: if (dec) begin
                    par_bit <= bit_val;
                    perr_p  <= (bit_val != exp_par);
                end
                S_STOP: begin
                    if (dec && !bit_val) ferr_p <= 1'b1;
                    if (dec && brk_hit)  brk_p  <= 1'b1;
                    if (bnd) stop_idx <= stop_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The completing decision is folded in directly since pending flags lag by a cycle.
    always_comb begin
        frame_nxt.data = shreg;
        frame_nxt.perr = perr_p;
        frame_nxt.ferr = ferr_p | ~bit_val;
        frame_nxt.brk  = brk_p | brk_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!dout_vld || dout_rdy) begin
                dout       <= frame_nxt.data;
                parity_err <= frame_nxt.perr;
                frame_err  <= frame_nxt.ferr;
                break_det  <= frame_nxt.brk;
                dout_vld   <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun    <= 1'b1;
            end
        end else begin
            overrun <= 1'b0;
            if (dout_vld && dout_rdy) begin
                dout       <= '0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                break_det  <= 1'b0;
                dout_vld   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed vector table, hand-written corner sequences,
// and randomized back-to-back frames checked against a frame-level model.
module tb_uart_rx_os;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int DW       = 8;
    localparam int SYNC     = 2;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BITC     = OS * DIV;
    localparam int NBITS    = DW + 1 + 1;
    localparam int LAT      = SYNC + 1 + (NBITS * OS + OS / 2 + 1) * DIV;

    logic          clk = 1'b0;
    logic          rst, rx, dout_rdy;
    logic [DW-1:0] dout;
    logic          dout_vld, parity_err, frame_err, break_det, overrun, busy;

    uart_rx_os #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_WIDTH(DW),
        .PARITY_MODE(1), .STOP_BITS(1), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .parity_err(parity_err), .frame_err(frame_err),
        .break_det(break_det), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p, e_ferr, e_perr, e_brk;
        int         cyc;
    } out_t;

    typedef struct {
        logic [7:0] d;
        logic       p, s;
        logic [7:0] e_d;
        logic       e_perr, e_ferr, e_brk;
    } vec_t;

    out_t outq[$];
    out_t expq[$];
    int   cyc = 0;
    int   ovr_cnt = 0;
    int   fall_cyc;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic out_t mk_out(logic [7:0] d, logic pe, logic fe, logic bk, int c);
        out_t r;
        r.d = d; r.p = 1'b0; r.e_perr = pe; r.e_ferr = fe; r.e_brk = bk; r.cyc = c;
        return r;
    endfunction

    // Frame-level reference: what the line carried decides what the host sees.
    function automatic out_t model(logic [7:0] d, logic p, logic s);
        logic brk;
        brk = (d == 8'h00) && !p && !s;
        return mk_out(brk ? 8'h00 : d, p != (^d), !s, brk, 0);
    endfunction

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dout_vld && dout_rdy)
            outq.push_back(mk_out(dout, parity_err, frame_err, break_det, cyc + 1));
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int bc, input int gap_bits);
        fall_cyc = cyc;
        rx = 1'b0;
        wait_clks(bc);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(bc);
        end
        rx = p;
        wait_clks(bc);
        rx = s;
        wait_clks(bc);
        rx = 1'b1;
        wait_clks(gap_bits * bc);
    endtask

    task automatic chk_out(input string name, input int idx, input out_t e);
        if (idx >= outq.size()) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no output frame, expected dout=%0h", name, e.d);
        end else begin
            chk({name, ".dout"}, outq[idx].d, e.d);
            chk({name, ".perr"}, outq[idx].e_perr, e.e_perr);
            chk({name, ".ferr"}, outq[idx].e_ferr, e.e_ferr);
            chk({name, ".brk"}, outq[idx].e_brk, e.e_brk);
        end
    endtask

    initial begin
        repeat (95_000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[5];
        int   base, ovr0, lat;
        logic [7:0] rd;
        logic rp, rs;
        int   rbc;

        tv[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tv[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        tv[2] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
        tv[3] = '{8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0};
        tv[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};

        rst = 1'b0; rx = 1'b1; dout_rdy = 1'b1;
        #1;
        chk("reset.dout_vld", dout_vld, 0);
        chk("reset.dout", dout, 0);
        chk("reset.busy", busy, 0);
        chk("reset.flags", {parity_err, frame_err, break_det, overrun}, 0);
        wait_clks(3);
        rst = 1'b1;
        wait_clks(5);

        for (int i = 0; i < 5; i++) begin
            base = outq.size();
            send_frame(tv[i].d, tv[i].p, tv[i].s, BITC, 2);
            chk($sformatf("vec%0d.count", i), outq.size() - base, 1);
            chk_out($sformatf("vec%0d", i), base,
                    mk_out(tv[i].e_d, tv[i].e_perr, tv[i].e_ferr, tv[i].e_brk, 0));
            if (i == 0 && outq.size() > base) begin
                lat = outq[base].cyc - fall_cyc;
                n_chk++;
                if (lat < LAT - 1 || lat > LAT + 1) begin
                    n_fail++;
                    $display("FAIL latency: got %0d, expected %0d +/-1", lat, LAT);
                end
            end
        end

        // Line break: 20 bit times low yields exactly one break frame.
        base = outq.size();
        rx = 1'b0;
        wait_clks(20 * BITC);
        chk("break.busy_low_line", busy, 0);
        rx = 1'b1;
        wait_clks(3 * BITC);
        chk("break.count", outq.size() - base, 1);
        chk_out("break", base, mk_out(8'h00, 1'b0, 1'b1, 1'b1, 0));

        // Overrun: second frame dropped while first is held.
        dout_rdy = 1'b0;
        ovr0 = ovr_cnt;
        base = outq.size();
        send_frame(8'h11, 1'b0, 1'b1, BITC, 1);
        send_frame(8'h22, 1'b0, 1'b1, BITC, 2);
        chk("ovr.dout_vld", dout_vld, 1);
        chk("ovr.dout", dout, 8'h11);
        chk("ovr.pulses", ovr_cnt - ovr0, 1);
        chk("ovr.no_handshake", outq.size() - base, 0);
        dout_rdy = 1'b1;
        wait_clks(2);
        chk("ovr.vld_after_hs", dout_vld, 0);
        chk("ovr.dout_after_hs", dout, 0);
        chk("ovr.hs_count", outq.size() - base, 1);
        chk_out("ovr.held", base, mk_out(8'h11, 1'b0, 1'b0, 1'b0, 0));

        // Glitch: 3-clock low pulse starts then aborts a frame.
        base = outq.size();
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(3);
        chk("glitch.busy_start", busy, 1);
        wait_clks(2 * BITC);
        chk("glitch.busy_end", busy, 0);
        chk("glitch.count", outq.size() - base, 0);

        // Reset mid-frame while a frame is held.
        dout_rdy = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, BITC, 1);
        chk("rstm.held_vld", dout_vld, 1);
        chk("rstm.held_dout", dout, 8'h5A);
        rx = 1'b0;
        wait_clks(BITC);
        rd = 8'h99;
        for (int i = 0; i < 4; i++) begin
            rx = rd[i];
            wait_clks(BITC);
        end
        wait_clks(BITC / 2);
        chk("rstm.busy_pre", busy, 1);
        rst = 1'b0;
        #1;
        chk("rstm.busy", busy, 0);
        chk("rstm.vld", dout_vld, 0);
        chk("rstm.dout", dout, 0);
        chk("rstm.flags", {parity_err, frame_err, break_det, overrun}, 0);
        rx = 1'b1;
        dout_rdy = 1'b1;
        wait_clks(5);
        rst = 1'b1;
        base = outq.size();
        wait_clks(2 * BITC);
        chk("rstm.no_output", outq.size() - base, 0);
        send_frame(8'h42, 1'b0, 1'b1, BITC, 2);
        chk("rstm.next_count", outq.size() - base, 1);
        chk_out("rstm.next", base, mk_out(8'h42, 1'b0, 1'b0, 1'b0, 0));

        // Randomized back-to-back frames with per-frame baud skew up to ~2.5%.
        base = outq.size();
        for (int i = 0; i < 16; i++) begin
            rd = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 6) != 0);
            rbc = $urandom_range(156, 164);
            expq.push_back(model(rd, rp, rs));
            send_frame(rd, rp, rs, rbc, rs ? 0 : 1);
        end
        wait_clks(2 * BITC);
        chk("rand.count", outq.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk_out($sformatf("rand%0d", i), base + i, expq[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised UART receiver with an internal oversampling baud generator, running on a single system clock. It replaces the external baud-clock receiver. Added features: configurable data width, parity mode and stop-bit count; 3-sample majority voting at mid-bit; framing, parity, overrun and break detection; and a ready/valid output register. It sits between the pad-side `rx` line and the host-side byte consumer.

## Interface
Parameters:
- CLK_FREQ, 16_000_000: system clock frequency, Hz
- BAUD_RATE, 9_600: line rate, bit/s
- OVERSAMPLE, 16: ticks per bit; even, ≥8
- DATA_WIDTH, 8: data bits per frame, 5..9
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1: 1 or 2
- SYNC_STAGES, 2: input synchroniser depth, ≥2

Ports (clock and reset first):
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- rx  in  1  serial input, asynchronous, idle high
- dout  out  DATA_WIDTH  received data, LSB = first bit on line
- dout_vld  out  1  dout and flags hold a frame
- dout_rdy  in  1  consumer accepts when dout_vld & dout_rdy
- parity_err  out  1  parity mismatch on held frame (0 if PARITY_MODE = 0)
- frame_err  out  1  a stop bit was sampled low on held frame
- break_det  out  1  held frame is a line break
- overrun  out  1  one-cycle pulse: completed frame dropped
- busy  out  1  FSM not in IDLE

## Operation
- Tick generator:
  - DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer truncation.
  - Counter runs 0..DIV-1; one-cycle tick on DIV-1.
  - Counter clears on start-edge detection.
- Synchroniser: SYNC_STAGES flops on rx, reset to 1. All logic uses the synchronised signal rxs.
- Sample counter: 0..OVERSAMPLE-1, advances on tick; wraps to 0 at each bit boundary.
- Majority sampling:
  - Samples are taken on ticks with sample count OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Bit value = majority of the three; decided on the third sample.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START: on rxs falling edge (previous 1, current 0). Clear tick and sample counters.
  - START: decided bit 1 → false start, back to IDLE, no output. Decided 0 → continue to the bit boundary, then DATA.
  - DATA: shift DATA_WIDTH bits, LSB first. Then PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: expected bit = XOR(data) for even mode, ~XOR(data) for odd mode. Mismatch sets pending parity_err.
  - STOP: STOP_BITS bits. Any stop bit decided 0 sets pending frame_err.
  - Frame completes on the decision of the last stop bit, and the FSM returns to IDLE. Remaining stop-bit time is not waited out.
- Break: all data bits 0, parity bit 0 (if present) and the first stop bit 0 → break_det=1, frame_err=1, dout=0.
- After a break or frame error, IDLE re-arms only on a new falling edge, so rx must return high first.
- Output register, on frame completion:
  - If dout_vld=0, or dout_vld & dout_rdy in the same cycle: load dout and the three flags, and dout_vld=1.
  - Otherwise: drop the frame, pulse overrun for one cycle, and leave the held contents unchanged.
- Handshake: dout_vld & dout_rdy with no completion in that cycle → dout_vld=0. dout and flags clear to 0.
- Reset (any time, including mid-frame):
  - FSM → IDLE; all counters → 0; synchroniser → 1.
  - dout=0, dout_vld=0, all flags=0, overrun=0, busy=0.
  - Any partial frame is discarded.

## Timing
- Edge detect: rx fall to busy=1 takes SYNC_STAGES+1 clocks.
- Frame completion: the decision of the last stop bit occurs at bit-index N = DATA_WIDTH + (PARITY_MODE≠0) + STOP_BITS. It lands (N*OVERSAMPLE + OVERSAMPLE/2+1)*DIV clocks after edge detection, ±1 clock.
- dout_vld and flags rise one clock after that decision. overrun pulses in the same cycle that dout_vld would have risen.
- busy falls in the same cycle dout_vld rises.
- The next start edge can be detected on the clock after busy falls. Back-to-back frames with 1 stop bit must be received without loss.
- Baud error tolerance: ≥±3% with OVERSAMPLE=16.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 (DIV=10), DATA_WIDTH=8, PARITY_MODE=1, STOP_BITS=1.

- Send 0xA5 with parity 0 and stop 1, dout_rdy=1 → dout=0xA5, dout_vld for 1 cycle, all flags 0.
- Send 0x3C with parity bit forced 1 → dout=0x3C, parity_err=1, frame_err=0.
- Send 0x55 with stop bit 0, then rx high → frame_err=1, break_det=0. The next frame, 0x0F, is received correctly.
- Hold rx low for 20 bit times, then release → exactly one output with dout=0, break_det=1, frame_err=1. No further output until the next falling edge.
- dout_rdy=0; send 0x11 then 0x22 → dout stays 0x11, overrun pulses once. After the handshake, dout_vld=0.
- 3-clock low glitch on idle line → false start, no output. Then assert rst low during the data bits of 0x99 → all outputs 0 immediately. The next frame, 0x42, is received correctly.
